apb_master_n: RTL and testbench
===============================

Name: apb_master_n

Overview:
- Parametrised APB3 bridge between the CPU data-bus request interface and NUM_SLAVES APB completers (RAM, GPO, GPI, GPIO, UART and future peripherals).
- Generalises the fixed 5-slave master:
  - slave count and address map set by parameters
  - byte strobes (PSTRB)
  - slave error propagation (PSLVERR)
  - decode-error response for unmapped addresses
  - optional access timeout
- Instantiated once per MCU top, between CPU_RV32I and the peripheral set.

Parameters:
- NUM_SLAVES, 5, number of APB completers (1..16).
- ADDR_W, 32, address width.
- DATA_W, 32, data width (multiple of 8).
- BASE_ADDR, 32'h1000_0000, start of the APB window.
- SLOT_SHIFT, 12, log2 of bytes per slave slot (4 KiB).
- TIMEOUT_CYCLES, 255, ACCESS-phase wait limit. Used only with APB_TIMEOUT_EN; 0 disables.

Ports:
- PCLK  in  1  clock; all logic rising-edge.
- PRESET  in  1  synchronous, active-low reset.
- transfer  in  1  single-cycle request strobe; sampled only in IDLE.
- write  in  1  1 = write, 0 = read.
- addr  in  ADDR_W  byte address.
- wdata  in  DATA_W  write data.
- strb  in  DATA_W/8  write byte enables.
- rdata  out  DATA_W  read data; valid while ready=1.
- ready  out  1  one-cycle completion pulse.
- err  out  1  completion with error; valid while ready=1.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PENABLE  out  1  APB access phase.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes; forced 0 on reads.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PRDATA  in  NUM_SLAVES*DATA_W  packed read data; slave i at [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset (PRESET=0 at a PCLK edge):
  - state IDLE
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rdata, ready, err all 0; timeout counter 0.
  - Reset mid-transfer drops PSEL/PENABLE at that edge; the aborted request never gets ready.
- Decode: slot = (addr - BASE_ADDR) >> SLOT_SHIFT. Address is mapped iff addr >= BASE_ADDR and slot < NUM_SLAVES; anything else is a decode error.
- IDLE:
  - transfer=1 and mapped: latch addr, wdata, write, strb and slot into PADDR/PWDATA/PWRITE/PSTRB; go to SETUP.
  - transfer=1 and unmapped: go to DERR.
  - transfer=0: stay in IDLE.
- SETUP (1 cycle): PSEL[slot]=1, PENABLE=0; go to ACCESS.
- ACCESS: PSEL[slot]=1, PENABLE=1.
  - PREADY[slot]=1: same cycle ready=1, rdata=PRDATA slice (0 on writes), err=PSLVERR[slot]; go to IDLE.
  - Otherwise stay in ACCESS; PADDR, PWDATA, PWRITE and PSTRB are held stable.
- DERR (1 cycle): ready=1, err=1, rdata=0, no PSEL asserted; go to IDLE.
- Latency:
  - zero-wait slave: transfer at cycle N, ready at cycle N+2.
  - decode error: ready at cycle N+1.
  - each wait state adds 1 cycle.
- transfer while not in IDLE is ignored and not queued.
- Back-to-back: a new transfer is accepted in the IDLE cycle directly after completion.
- PREADY/PSLVERR from non-selected slaves are ignored.
- ready, err and rdata are combinational from state and selected inputs.
- ready=0 implies err=0 and rdata=0.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Defined:
  - an 8..16-bit counter clears on SETUP and increments each ACCESS cycle with PREADY[slot]=0.
  - when it reaches TIMEOUT_CYCLES: ready=1, err=1, rdata=0, PSEL/PENABLE drop, go to IDLE.
  - a PREADY arriving in that same cycle wins (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is ignored.

Decomposition:
- Package apb_pkg holds:
  - typedef enum apb_state_t {IDLE, SETUP, ACCESS, DERR}
  - default BASE_ADDR and SLOT_SHIFT localparams
  - per-peripheral slot-index constants RAM=0, GPO=1, GPI=2, GPIO=3, UART=4
- Sub-module apb_addr_decoder: combinational; addr in, slot index + mapped flag out. Reused by the testbench scoreboard.

Test Plan:
- Write 0x1000_0004 (slot 0), wdata 0xA5A5_1234, strb 4'b0011, PREADY0 tied 1:
  - SETUP shows PSEL=5'b00001, PENABLE=0.
  - ACCESS shows PENABLE=1, PSTRB=4'b0011.
  - ready and err=0 two cycles after transfer.
- Read 0x1000_4000 (slot 4), PREADY4 low for 3 cycles, PRDATA4=0x0000_00C3:
  - ready 5 cycles after transfer, rdata=0xC3.
  - PADDR stable throughout.
- Read 0x2000_0000 and 0x1000_5000:
  - ready and err=1 one cycle after transfer.
  - PSEL never asserted.
  - rdata=0.
- Write to slot 2 with PSLVERR2=1 on the completion cycle: ready=1, err=1.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=8, PREADY3 stuck 0:
  - ready and err=1 after exactly 8 ACCESS cycles, then IDLE.
  - Repeat with PREADY3 rising on cycle 8: err=0.
- PRESET=0 asserted in ACCESS, then released:
  - PSEL=0 and no ready pulse.
  - Next transfer completes normally; transfers issued while busy produce no extra ready.

Source files
------------

// File: rtl/apb_master_n_pkg.sv
// apb_pkg: shared types and constants for the parametrised APB3 master.
//   apb_state_t      : bridge FSM states
//   APB_BASE_ADDR    : default start of the APB window
//   APB_SLOT_SHIFT   : default log2 of bytes per slave slot
//   SLOT_W / TMO_W   : slot index width (up to 16 slaves) and timeout counter width
//   RAM..UART        : slot indices of the standard MCU peripherals
package apb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} apb_state_t;

  localparam logic [31:0] APB_BASE_ADDR  = 32'h1000_0000;
  localparam int          APB_SLOT_SHIFT = 12;
  localparam int          SLOT_W         = 4;
  localparam int          TMO_W          = 16;

  localparam int RAM  = 0;
  localparam int GPO  = 1;
  localparam int GPI  = 2;
  localparam int GPIO = 3;
  localparam int UART = 4;
endpackage

// File: rtl/apb_master_n_if.sv
// apb_master_n_if: CPU request side plus APB completer side of the bridge.
//   CPU side : transfer, write, addr, wdata, strb -> rdata, ready, err
//   APB side : PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL -> PRDATA, PREADY, PSLVERR
//   modport master : the bridge's view; modport slave : the environment's view.
interface apb_master_n_if #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic                         transfer;
  logic                         write;
  logic [ADDR_W-1:0]            addr;
  logic [DATA_W-1:0]            wdata;
  logic [STRB_W-1:0]            strb;
  logic [DATA_W-1:0]            rdata;
  logic                         ready;
  logic                         err;

  logic [ADDR_W-1:0]            PADDR;
  logic                         PWRITE;
  logic                         PENABLE;
  logic [DATA_W-1:0]            PWDATA;
  logic [STRB_W-1:0]            PSTRB;
  logic [NUM_SLAVES-1:0]        PSEL;
  logic [NUM_SLAVES*DATA_W-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]        PREADY;
  logic [NUM_SLAVES-1:0]        PSLVERR;

  modport master (
    input  transfer, write, addr, wdata, strb, PRDATA, PREADY, PSLVERR,
    output rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL
  );

  modport slave (
    output transfer, write, addr, wdata, strb, PRDATA, PREADY, PSLVERR,
    input  rdata, ready, err, PADDR, PWRITE, PENABLE, PWDATA, PSTRB, PSEL
  );
endinterface

// File: rtl/apb_master_n_addr_decoder.sv
// apb_addr_decoder: combinational address decode for the APB window.
//   addr   in  : byte address
//   slot   out : (addr - BASE_ADDR) >> SLOT_SHIFT, meaningful only when mapped
//   mapped out : addr >= BASE_ADDR and slot < NUM_SLAVES
module apb_addr_decoder
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES = 5,
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(APB_BASE_ADDR),
  parameter int                SLOT_SHIFT = APB_SLOT_SHIFT
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SLOT_W-1:0] slot,
  output logic              mapped
);
  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] slot_full;

  always_comb begin
    offs      = addr - BASE_ADDR;
    slot_full = offs >> SLOT_SHIFT;
    // Full-width slot compare so far-away addresses cannot alias into a slot.
    mapped    = (addr >= BASE_ADDR) && (slot_full < ADDR_W'(NUM_SLAVES));
    slot      = slot_full[SLOT_W-1:0];
  end
endmodule

// File: rtl/apb_master_n.sv
// apb_master_n: APB3 bridge from the CPU data-bus request to NUM_SLAVES completers.
//   PCLK   : clock, rising edge
//   PRESET : synchronous active-low reset
//   bus    : apb_master_n_if.master (CPU request/response + APB bus)
// Optional macro APB_TIMEOUT_EN: ACCESS phase aborts with err after
// TIMEOUT_CYCLES wait cycles (0 = never). Without it ACCESS waits forever.
module apb_master_n
  import apb_pkg::*;
#(
  parameter int                NUM_SLAVES     = 5,
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = ADDR_W'(APB_BASE_ADDR),
  parameter int                SLOT_SHIFT     = APB_SLOT_SHIFT,
  parameter int                TIMEOUT_CYCLES = 255
) (
  input  logic            PCLK,
  input  logic            PRESET,
  apb_master_n_if.master  bus
);
  localparam int STRB_W = DATA_W / 8;

  apb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [STRB_W-1:0] pstrb_q, pstrb_d;
  logic [SLOT_W-1:0] slot_q, slot_d;

  logic [SLOT_W-1:0]     dec_slot;
  logic                  dec_mapped;
  logic                  sel_ready, sel_err, timeout;
  logic [DATA_W-1:0]     sel_rdata;
  logic [NUM_SLAVES-1:0] psel;
  logic                  penable, ready_c, err_c;
  logic [DATA_W-1:0]     rdata_c;

  apb_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .BASE_ADDR  (BASE_ADDR),
    .SLOT_SHIFT (SLOT_SHIFT)
  ) u_dec (
    .addr   (bus.addr),
    .slot   (dec_slot),
    .mapped (dec_mapped)
  );

  // Only the selected completer's response is ever looked at.
  assign sel_ready = bus.PREADY[slot_q];
  assign sel_err   = bus.PSLVERR[slot_q];
  assign sel_rdata = bus.PRDATA[int'(slot_q)*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
  logic [TMO_W-1:0] tmo_q, tmo_d;

  // Counts ACCESS cycles without PREADY; fires on the cycle the count
  // would reach TIMEOUT_CYCLES, so a PREADY in that cycle still wins.
  always_comb begin
    tmo_d   = tmo_q;
    timeout = 1'b0;
    if (state_q == SETUP) begin
      tmo_d = '0;
    end else if (state_q == ACCESS && !sel_ready) begin
      tmo_d   = tmo_q + 1'b1;
      timeout = (TIMEOUT_CYCLES != 0) && (tmo_d == TMO_W'(TIMEOUT_CYCLES));
    end
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  // TIMEOUT_CYCLES has no effect in this build; the compare folds to 0.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d  = state_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    pwrite_d = pwrite_q;
    pstrb_d  = pstrb_q;
    slot_d   = slot_q;
    psel     = '0;
    penable  = 1'b0;
    ready_c  = 1'b0;
    err_c    = 1'b0;
    rdata_c  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.transfer) begin
          if (dec_mapped) begin
            paddr_d  = bus.addr;
            pwdata_d = bus.wdata;
            pwrite_d = bus.write;
            pstrb_d  = bus.write ? bus.strb : '0;
            slot_d   = dec_slot;
            state_d  = SETUP;
          end else begin
            state_d  = DERR;
          end
        end
      end
      SETUP: begin
        psel[slot_q] = 1'b1;
        state_d      = ACCESS;
      end
      ACCESS: begin
        psel[slot_q] = 1'b1;
        penable      = 1'b1;
        if (sel_ready) begin
          ready_c = 1'b1;
          err_c   = sel_err;
          rdata_c = pwrite_q ? '0 : sel_rdata;
          state_d = IDLE;
        end else if (timeout) begin
          ready_c = 1'b1;
          err_c   = 1'b1;
          state_d = IDLE;
        end
      end
      DERR: begin
        ready_c = 1'b1;
        err_c   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= '0;
      slot_q   <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      slot_q   <= slot_d;
    end
  end

  // Completion is masked while reset is held so an aborted access never
  // reports ready, even in the cycle before the reset edge.
  assign bus.ready   = ready_c & PRESET;
  assign bus.err     = err_c & PRESET;
  assign bus.rdata   = PRESET ? rdata_c : '0;
  assign bus.PSEL    = psel;
  assign bus.PENABLE = penable;
  assign bus.PADDR   = paddr_q;
  assign bus.PWDATA  = pwdata_q;
  assign bus.PWRITE  = pwrite_q;
  assign bus.PSTRB   = pstrb_q;
endmodule

// File: tb/tb_apb_master_n.sv
module tb_apb_master_n;
  import apb_pkg::*;

  localparam int          NS   = 5;
  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          SW   = DW / 8;
  localparam int          TO   = 8;
  localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef APB_TIMEOUT_EN
  localparam int TMO = TO;
`else
  localparam int TMO = 0;
`endif

  logic PCLK = 1'b0;
  logic PRESET = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_master_n_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_master_n #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE),
    .SLOT_SHIFT(12), .TIMEOUT_CYCLES(TO)
  ) dut (.PCLK(PCLK), .PRESET(PRESET), .bus(bus));

  logic [SLOT_W-1:0] d_slot;
  logic              d_map;
  apb_addr_decoder #(.NUM_SLAVES(NS), .ADDR_W(AW), .BASE_ADDR(BASE), .SLOT_SHIFT(12))
    u_dec_chk (.addr(bus.addr), .slot(d_slot), .mapped(d_map));

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  // Model of the transaction in flight: what was asked for and how the
  // selected completer behaves (wait states, error, read data).
  bit          act = 0;
  int          m_acc, m_slot, m_w;
  bit          m_map, m_wr, m_slverr;
  logic [31:0] m_addr, m_wdata, m_rd;
  logic [SW-1:0] m_strb;
  // What the APB address/data lines must hold when no transfer is in flight.
  logic [31:0] lat_addr = '0, lat_wdata = '0;
  logic        lat_wr = 1'b0;
  logic [SW-1:0] lat_strb = '0;

  int          rdy_d, rdy_cnt = 0;
  logic [31:0] rdy_data;
  logic        rdy_err;
  bit          psel_seen;
  logic [NS-1:0] cap_psel [0:31];
  logic          cap_pen  [0:31];
  logic [31:0]   cap_paddr[0:31];
  logic [SW-1:0] cap_pstrb[0:31];

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  function automatic bit f_map(input logic [31:0] a);
    return (a >= BASE) && (((a - BASE) >> 12) < NS);
  endfunction

  function automatic bit f_tmo();
    return m_map && TMO > 0 && m_w >= TMO;
  endfunction

  // Cycle offset (from the transfer cycle) at which ready must pulse.
  function automatic int f_end();
    if (!m_map)  return 1;
    if (f_tmo()) return 1 + TMO;
    return 2 + m_w;
  endfunction

  always @(negedge PCLK) begin
    logic [NS-1:0] e_psel;
    logic          e_pen, e_rdy, e_err, e_pwr;
    logic [31:0]   e_rdata, e_paddr, e_pwdata;
    logic [SW-1:0] e_pstrb;
    int d;
    if (!PRESET) begin
      chk("rst_ready", bus.ready, 0);
      chk("rst_err", bus.err, 0);
    end else begin
      e_psel = '0; e_pen = 0; e_rdy = 0; e_err = 0; e_rdata = '0;
      e_paddr = lat_addr; e_pwdata = lat_wdata; e_pwr = lat_wr; e_pstrb = lat_strb;
      d = act ? cyc - m_acc : -1;
      if (act && m_map && d >= 1) begin
        e_paddr = m_addr; e_pwdata = m_wdata; e_pwr = m_wr;
        e_pstrb = m_wr ? m_strb : '0;
      end
      if (act && !m_map && d == 1) begin
        e_rdy = 1; e_err = 1;
      end else if (act && m_map && d >= 1 && d <= f_end()) begin
        e_psel = NS'(1) << m_slot;
        e_pen  = (d >= 2);
        if (d == f_end()) begin
          e_rdy = 1;
          if (f_tmo()) e_err = 1;
          else begin
            e_err   = m_slverr;
            e_rdata = m_wr ? '0 : m_rd;
          end
        end
      end
      chk("psel", bus.PSEL, e_psel);
      chk("penable", bus.PENABLE, e_pen);
      chk("ready", bus.ready, e_rdy);
      chk("err", bus.err, e_err);
      chk("rdata", bus.rdata, e_rdata);
      chk("paddr", bus.PADDR, e_paddr);
      chk("pwdata", bus.PWDATA, e_pwdata);
      chk("pwrite", bus.PWRITE, e_pwr);
      chk("pstrb", bus.PSTRB, e_pstrb);
      chk("dec_mapped", d_map, f_map(bus.addr));
      if (f_map(bus.addr)) chk("dec_slot", d_slot, (bus.addr - BASE) >> 12);
      if (act && d >= 0 && d < 32) begin
        cap_psel[d] = bus.PSEL; cap_pen[d] = bus.PENABLE;
        cap_paddr[d] = bus.PADDR; cap_pstrb[d] = bus.PSTRB;
      end
      if (bus.ready === 1'b1) begin
        rdy_cnt++;
        rdy_d = act ? d : -99; rdy_data = bus.rdata; rdy_err = bus.err;
      end
      if (bus.PSEL != '0) psel_seen = 1;
    end
  end

  task automatic drive_slaves(input int d);
    for (int i = 0; i < NS; i++) begin
      if (act && m_map && i == m_slot) begin
        bus.PREADY[i]  = (d >= 2 + m_w);
        bus.PSLVERR[i] = (d >= 2 + m_w) ? m_slverr : 1'($urandom_range(0, 1));
        bus.PRDATA[i*DW +: DW] = m_rd;
      end else begin
        bus.PREADY[i]  = 1'($urandom_range(0, 1));
        bus.PSLVERR[i] = 1'($urandom_range(0, 1));
        bus.PRDATA[i*DW +: DW] = $urandom();
      end
    end
  endtask

  // Called just after a rising edge; issues one request in that cycle and
  // returns just after the edge that starts the next IDLE cycle.
  task automatic xfer(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [SW-1:0] st, input int w, input bit se,
                      input logic [31:0] rd, input bit noise);
    int e;
    m_wr = wr; m_addr = a; m_wdata = wd; m_strb = st; m_w = w; m_slverr = se;
    m_rd = rd; m_map = f_map(a); m_slot = int'((a - BASE) >> 12); m_acc = cyc; act = 1;
    bus.transfer = 1; bus.write = wr; bus.addr = a; bus.wdata = wd; bus.strb = st;
    drive_slaves(0);
    e = f_end();
    for (int d = 1; d <= e; d++) begin
      @(posedge PCLK); #1;
      bus.transfer = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        bus.addr = $urandom(); bus.write = 1'($urandom_range(0, 1));
        bus.wdata = $urandom(); bus.strb = SW'($urandom());
      end
      drive_slaves(d);
    end
    @(posedge PCLK); #1;
    bus.transfer = 0; act = 0;
    if (m_map) begin
      lat_addr = m_addr; lat_wdata = m_wdata; lat_wr = m_wr;
      lat_strb = m_wr ? m_strb : '0;
    end
    drive_slaves(0);
  endtask

  task automatic rst_mid();
    m_wr = 0; m_addr = 32'h1000_1010; m_wdata = 32'h1234_5678; m_strb = '1; m_w = 20;
    m_slverr = 0; m_rd = 32'hDEAD_BEEF; m_map = 1; m_slot = 1; m_acc = cyc; act = 1;
    bus.transfer = 1; bus.write = 0; bus.addr = m_addr; bus.wdata = m_wdata; bus.strb = '1;
    drive_slaves(0);
    for (int d = 1; d <= 3; d++) begin
      @(posedge PCLK); #1;
      bus.transfer = 0;
      drive_slaves(d);
    end
    PRESET = 0; bus.PREADY = '1; act = 0;
    lat_addr = '0; lat_wdata = '0; lat_wr = 0; lat_strb = '0;
    @(posedge PCLK); #1;
    @(posedge PCLK); #1;
    PRESET = 1;
    @(posedge PCLK); #1;
  endtask

  initial begin
    int snap;
    logic [31:0] a;
    bus.transfer = 0; bus.write = 0; bus.addr = '0; bus.wdata = '0; bus.strb = '0;
    bus.PRDATA = '0; bus.PREADY = '0; bus.PSLVERR = '0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1;
    @(posedge PCLK); #1;
    chk("reset_psel", bus.PSEL, 0);
    chk("reset_paddr", bus.PADDR, 0);
    chk("reset_ready", bus.ready, 0);

    // Zero-wait write to RAM slot.
    rdy_d = -1;
    xfer(1, 32'h1000_0004, 32'hA5A5_1234, 4'b0011, 0, 0, 32'h1111_2222, 0);
    chk("t1_setup_psel", cap_psel[1], 5'b00001);
    chk("t1_setup_pen", cap_pen[1], 0);
    chk("t1_access_pen", cap_pen[2], 1);
    chk("t1_access_pstrb", cap_pstrb[2], 4'b0011);
    chk("t1_ready_lat", rdy_d, 2);
    chk("t1_err", rdy_err, 0);

    // Read from UART slot with three wait states.
    rdy_d = -1;
    xfer(0, 32'h1000_4000, 32'h5555_AAAA, 4'hF, 3, 0, 32'h0000_00C3, 0);
    chk("t2_ready_lat", rdy_d, 5);
    chk("t2_rdata", rdy_data, 32'hC3);
    chk("t2_pstrb_read", cap_pstrb[2], 0);
    for (int d = 1; d <= 5; d++) chk("t2_paddr_stable", cap_paddr[d], 32'h1000_4000);

    // Unmapped addresses: above the window's first byte region and just past the last slot.
    psel_seen = 0;
    rdy_d = -1;
    xfer(0, 32'h2000_0000, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    chk("t3a_ready_lat", rdy_d, 1);
    chk("t3a_err", rdy_err, 1);
    chk("t3a_rdata", rdy_data, 0);
    rdy_d = -1;
    xfer(0, 32'h1000_5000, 0, 0, 0, 0, 32'hFFFF_FFFF, 0);
    chk("t3b_ready_lat", rdy_d, 1);
    chk("t3b_err", rdy_err, 1);
    chk("t3_no_psel", psel_seen, 0);

    // Slave error on a write to GPI slot.
    rdy_d = -1;
    xfer(1, 32'h1000_2000, 32'h0BAD_F00D, 4'hF, 1, 1, 32'h0, 0);
    chk("t4_ready_lat", rdy_d, 3);
    chk("t4_err", rdy_err, 1);

`ifdef APB_TIMEOUT_EN
    rdy_d = -1;
    xfer(0, 32'h1000_3000, 0, 0, 30, 0, 32'h0000_0077, 0);
    chk("t5_tmo_lat", rdy_d, 9);
    chk("t5_tmo_err", rdy_err, 1);
    chk("t5_tmo_rdata", rdy_data, 0);
    rdy_d = -1;
    xfer(0, 32'h1000_3000, 0, 0, 7, 0, 32'h0000_0077, 0);
    chk("t5_late_lat", rdy_d, 9);
    chk("t5_late_err", rdy_err, 0);
    chk("t5_late_rdata", rdy_data, 32'h77);
`endif

    // Reset in the middle of ACCESS, then a noisy transfer.
    snap = rdy_cnt;
    rst_mid();
    chk("t6_no_ready_on_reset", rdy_cnt, snap);
    rdy_d = -1;
    xfer(0, 32'h1000_1000, 0, 0, 2, 0, 32'hCAFE_0001, 1);
    chk("t6_after_reset_lat", rdy_d, 4);
    chk("t6_one_ready", rdy_cnt, snap + 1);

    // Randomized traffic, back-to-back or with idle gaps.
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: a = BASE + ($urandom_range(0, NS - 1) << 12) + ($urandom_range(0, 1023) << 2);
        3:       a = BASE + (NS << 12) + $urandom_range(0, 4095);
        4:       a = BASE - 1 - $urandom_range(0, 1023);
        default: a = $urandom();
      endcase
      xfer(1'($urandom_range(0, 1)), a, $urandom(), SW'($urandom()),
           ($urandom_range(0, 7) == 0) ? $urandom_range(4, 11) : $urandom_range(0, 3),
           1'($urandom_range(0, 1)), $urandom(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin @(posedge PCLK); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
